// File: rtl/seg_scan_if.sv
// Display-side bundle for the two-digit scan multiplexer.
// The master drives the decoded digits and lap/blank controls;
// the slave (the multiplexer) drives the shared segment bus and digit enables.
interface seg_scan_if;
    logic [6:0] seg_0;
    logic [6:0] seg_1;
    logic       lap_pulse;
    logic       blank_lead;
    logic [6:0] seg_out;
    logic [1:0] digit_en;
    logic       lap_active;

    modport master (
        output seg_0,
        output seg_1,
        output lap_pulse,
        output blank_lead,
        input  seg_out,
        input  digit_en,
        input  lap_active
    );

    modport slave (
        input  seg_0,
        input  seg_1,
        input  lap_pulse,
        input  blank_lead,
        output seg_out,
        output digit_en,
        output lap_active
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Two-digit shared-segment display multiplexer with guard intervals,
// lap/hold freeze and optional leading-zero blanking of the tens digit.
//
// Scan FSM
//   state  | meaning
//   GUARD0 | all digits off before the ones digit (GUARD_CYCLES long)
//   DIG0   | ones digit enabled (REFRESH_DIV long)
//   GUARD1 | all digits off before the tens digit (GUARD_CYCLES long)
//   DIG1   | tens digit enabled (REFRESH_DIV long)
//
// Lap FSM
//   state  | meaning
//   LIVE   | display follows seg_0/seg_1
//   HELD   | display shows the values captured on the entering lap pulse
module seg_scan_mux #(
    parameter int         REFRESH_DIV   = 1000,
    parameter int         GUARD_CYCLES  = 16,
    parameter logic [6:0] ZERO_PATTERN  = 7'b0111111,
    parameter logic [6:0] BLANK_PATTERN = 7'b0000000
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int MAX_RG  = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int MAX_LEN = (MAX_RG > 2) ? MAX_RG : 2;
    localparam int CNT_W   = $clog2(MAX_LEN);

    localparam int R_LAST_I = (REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0;
    localparam int G_LAST_I = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] R_LAST = R_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] G_LAST = G_LAST_I[CNT_W-1:0];
    localparam bit   NO_GUARD = (GUARD_CYCLES == 0);

    typedef enum logic [1:0] {
        GUARD0 = 2'd0,
        DIG0   = 2'd1,
        GUARD1 = 2'd2,
        DIG1   = 2'd3
    } scan_t;

    typedef enum logic {
        LIVE = 1'b0,
        HELD = 1'b1
    } lap_t;

    scan_t            scan_st;
    scan_t            scan_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    lap_t             lap_st;
    lap_t             lap_nxt;
    logic             capture;
    logic [6:0]       held_0;
    logic [6:0]       held_1;

    logic [6:0]       src_0;
    logic [6:0]       src_1;
    logic [6:0]       seg_q;
    logic [6:0]       seg_nxt;
    logic [1:0]       en_q;
    logic [1:0]       en_nxt;

    // Scan sequencing: advance when the per-state cycle count reaches its length.
    // With no guard, GUARD0 is only ever visited out of reset and is left on the first edge.
    always_comb begin
        scan_nxt = scan_st;
        cnt_nxt  = cnt + 1'b1;
        case (scan_st)
            GUARD0: begin
                if (NO_GUARD || cnt == G_LAST) begin
                    scan_nxt = DIG0;
                    cnt_nxt  = '0;
                end
            end
            DIG0: begin
                if (cnt == R_LAST) begin
                    scan_nxt = NO_GUARD ? DIG1 : GUARD1;
                    cnt_nxt  = '0;
                end
            end
            GUARD1: begin
                if (NO_GUARD || cnt == G_LAST) begin
                    scan_nxt = DIG1;
                    cnt_nxt  = '0;
                end
            end
            DIG1: begin
                if (cnt == R_LAST) begin
                    scan_nxt = NO_GUARD ? DIG0 : GUARD0;
                    cnt_nxt  = '0;
                end
            end
            default: begin
                scan_nxt = GUARD0;
                cnt_nxt  = '0;
            end
        endcase
    end

    // Source selection uses the lap state before the edge, so a toggle shows from the following edge.
    always_comb begin
        src_0 = (lap_st == HELD) ? held_0 : bus.seg_0;
        src_1 = (lap_st == HELD) ? held_1 : bus.seg_1;
    end

    // Output decode from the upcoming scan state so outputs move on the same edge as the state.
    always_comb begin
        seg_nxt = BLANK_PATTERN;
        en_nxt  = 2'b00;
        case (scan_nxt)
            DIG0: begin
                en_nxt  = 2'b01;
                seg_nxt = src_0;
            end
            DIG1: begin
                en_nxt  = 2'b10;
                seg_nxt = (bus.blank_lead && src_1 == ZERO_PATTERN) ? BLANK_PATTERN : src_1;
            end
            default: begin
                en_nxt  = 2'b00;
                seg_nxt = BLANK_PATTERN;
            end
        endcase
    end

    // Scan state, cycle counter and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_st <= GUARD0;
            cnt     <= '0;
            seg_q   <= BLANK_PATTERN;
            en_q    <= 2'b00;
        end else begin
            scan_st <= scan_nxt;
            cnt     <= cnt_nxt;
            seg_q   <= seg_nxt;
            en_q    <= en_nxt;
        end
    end

    // Lap toggle: entering HELD captures the live digits; leaving keeps them.
    always_comb begin
        lap_nxt = lap_st;
        capture = 1'b0;
        if (bus.lap_pulse) begin
            if (lap_st == LIVE) begin
                lap_nxt = HELD;
                capture = 1'b1;
            end else begin
                lap_nxt = LIVE;
            end
        end
    end

    // Lap state register; independent of scan timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_st <= LIVE;
        end else begin
            lap_st <= lap_nxt;
        end
    end

    // Held digit registers, loaded only on entry to HELD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_0 <= BLANK_PATTERN;
            held_1 <= BLANK_PATTERN;
        end else if (capture) begin
            held_0 <= bus.seg_0;
            held_1 <= bus.seg_1;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.digit_en   = en_q;
    assign bus.lap_active = (lap_st == HELD);

endmodule
